// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared fetch-bridge state type and AXI encodings
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_DRAIN = 2'd3
    } bridge_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_uncached_axi_bridge_if.sv
// rtl/inst_uncached_axi_bridge_if.sv - AXI4 read-address and read-data channels
interface inst_uncached_axi_bridge_if #(
    parameter int ID_WIDTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) ();
    logic [ID_WIDTH-1:0] arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_WIDTH-1:0] rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_uncached_axi_bridge_chk.sv
// rtl/inst_uncached_axi_bridge_chk.sv - R-channel protocol checker for the fetch bridge
module inst_uncached_axi_bridge_chk #(
    parameter int ID_WIDTH = 4,
    parameter int AR_ID    = 0
) (
    input logic                clk,
    input logic                reset,
    input logic                rvalid,
    input logic                rready,
    input logic                rlast,
    input logic [ID_WIDTH-1:0] rid
);
    // rready is only low in IDLE/AR, so data there means the slave ran ahead of the address.
    a_rvalid_early: assert property (@(posedge clk) disable iff (reset) rvalid |-> rready);

    a_rbeat_shape: assert property (@(posedge clk) disable iff (reset)
        (rvalid && rready) |-> (rlast && rid == ID_WIDTH'(AR_ID)));
endmodule

// File: rtl/inst_uncached_axi_bridge.sv
// rtl/inst_uncached_axi_bridge.sv - uncached fetch request to single-beat AXI4 read, flush-aware
module inst_uncached_axi_bridge
    import cpu_bus_pkg::*;
#(
    parameter int ID_WIDTH = 4,
    parameter int AR_ID    = 0,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_valid,
    output logic              inst_err,
    output logic              inst_busy,
    inst_uncached_axi_bridge_if.master axi
);
    bridge_state_e     state;
    logic              kill;
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic              rready_q;

    assign axi.arid    = ID_WIDTH'(AR_ID);
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = SIZE_WORD;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign inst_busy   = (state != ST_IDLE);

    logic unused_sigs;
    assign unused_sigs = &{1'b0, axi.rid, axi.rlast, inst_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            kill       <= 1'b0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            inst_valid <= 1'b0;
            inst_err   <= 1'b0;
            inst_rdata <= '0;
        end else begin
            inst_valid <= 1'b0;
            inst_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    kill <= 1'b0;
                    if (inst_req && !flush) begin
                        araddr_q  <= {inst_addr[ADDR_W-1:2], 2'b00};
                        arvalid_q <= 1'b1;
                        state     <= ST_AR;
                    end
                end
                ST_AR: begin
                    // The address beat must complete even when killed; the data is dropped later.
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= (flush || kill) ? ST_DRAIN : ST_R;
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                ST_R: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        state    <= ST_IDLE;
                        if (!flush) begin
                            inst_rdata <= axi.rdata;
                            inst_valid <= 1'b1;
                            inst_err   <= (axi.rresp != RESP_OKAY);
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        kill     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/inst_uncached_axi_bridge.md
Name: inst_uncached_axi_bridge

Overview:
- Responder side of the fetch stage's uncached instruction-SRAM handshake (inst_valid / inst_rdata).
- Accepts one single-word fetch request per transaction and converts it to an AXI4 single-beat read (AR/R).
- Returns the instruction word with a one-cycle valid pulse.
- Honours exception flush: an in-flight AXI transaction is always completed on the bus, but its data is discarded.

Parameters:
- ID_WIDTH, 4, width of arid/rid
- AR_ID, 0, fixed ID driven on arid
- ADDR_W, 32, request and araddr width
- DATA_W, 32, instruction and rdata width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  in  1  fetch request; sampled only in IDLE
- inst_addr  in  ADDR_W  physical fetch address; low 2 bits forced to 0 on araddr
- flush  in  1  exception flush; kills the current/pending fetch
- inst_rdata  out  DATA_W  returned instruction; valid only while inst_valid=1
- inst_valid  out  1  one-cycle pulse, data returned
- inst_err  out  1  same-cycle qualifier with inst_valid: rresp != OKAY
- inst_busy  out  1  high whenever state != IDLE
- arid  out  ID_WIDTH  =AR_ID
- araddr  out  ADDR_W  registered address
- arlen  out  8  constant 0
- arsize  out  3  constant 3'b010
- arburst  out  2  constant INCR (2'b01)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  ID_WIDTH  ignored except for assertion (must equal AR_ID)
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rlast  in  1  must be 1 (single beat)
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset values: state=IDLE; arvalid=0; rready=0; inst_valid=0; inst_err=0; inst_rdata=0; araddr=0; inst_busy=0.
- States:
  - IDLE
  - AR: arvalid=1
  - R: rready=1, data wanted
  - DRAIN: rready=1, data discarded
- IDLE:
  - inst_req & !flush → register {inst_addr[31:2],2'b00} into araddr; go to AR.
  - inst_req & flush → stay IDLE, no request issued.
- AR:
  - arvalid held high and araddr stable until arready, per AXI rule; flush never drops arvalid.
  - arready: go to R, or to DRAIN if flush is asserted this cycle or a kill has been latched.
  - A flush while waiting sets the internal kill flag.
- R:
  - rvalid & !flush → latch rdata into inst_rdata; pulse inst_valid next cycle; inst_err = (rresp != 2'b00); go to IDLE.
  - rvalid & flush → discard, no pulse, go to IDLE.
  - flush without rvalid → go to DRAIN.
- DRAIN: rvalid → discard, go to IDLE, clear kill.
- Kill flag: cleared on entry to IDLE.
- Latency: req accepted at cycle N → arvalid=1 at N+1. With arready at N+1 and rvalid at N+2, inst_valid=1 at N+3 (minimum 3 cycles).
- inst_valid:
  - Registered and exactly one cycle wide.
  - Never asserted for a transaction that saw flush at any point after acceptance.
  - Flush in the same cycle as the pulse does not retract it; the consumer discards.
- Back-to-back: the cycle inst_valid is high, state is IDLE and a new inst_req is accepted. No bubble beyond the 3-cycle latency.
- At most one outstanding AXI read. inst_req while busy is ignored; the requester holds it.
- rvalid arriving in IDLE or AR is a protocol violation; simulation assertion fires, RTL ignores it.
- Reset mid-transaction returns to IDLE immediately. The system resets the AXI slave concurrently.

Decomposition:
- Shared package cpu_bus_pkg:
  - state enum (IDLE/AR/R/DRAIN)
  - AXI constants: BURST_INCR=2'b01, SIZE_WORD=3'b010, RESP_OKAY=2'b00
- Single flat module; no sub-module warranted.
- Assertions in a bound checker, not in the RTL.

Test Plan:
- Basic fetch: inst_req at addr 0xBFC00000; arready same cycle as arvalid; rvalid one cycle later with rdata 0x3C1DBFC0 → araddr=0xBFC00000, single inst_valid pulse with rdata 0x3C1DBFC0, inst_err=0, 3-cycle latency.
- AR backpressure plus flush: arready held low 5 cycles, flush at cycle 2, then arready; rvalid with 0x12345678 → arvalid stays high with stable address, R beat consumed, no inst_valid, busy falls after R beat.
- Flush in R with delayed data: rvalid arrives 4 cycles after flush → state DRAIN, rready=1, no pulse, returns IDLE, next request proceeds normally.
- Simultaneous flush and rvalid in R → no inst_valid, state IDLE next cycle.
- Error response: rresp=2'b10 → inst_valid=1 and inst_err=1 in the same cycle.
- Back-to-back requests: 0x100/0x104/0x108 with inst_req held continuously, slave zero-wait → three pulses, one every 3 cycles, in order. Then reset asserted mid-AR → outputs return to reset values next cycle.
